// File: rtl/bus_arbiter8.sv
// bus_arbiter8: 8-requester round-robin bus arbiter with a registered one-hot
// grant, a mux select that follows the grant, and a busy flag.
// Optional forced release after MAX_HOLD owner cycles: define ARB_TIMEOUT_EN.
// Without ARB_TIMEOUT_EN, Timeout is tied low and the hold counter is not built.
module bus_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Kerkesa,
  input  logic       Liro,
  output logic [7:0] Leje,
  output logic [2:0] s,
  output logic       Zene,
  output logic       Timeout
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Reject out-of-range hold limits when the design is elaborated.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter8: MAX_HOLD must be within 2..255");
  end

  state_e             state_q;
  logic [N-1:0]       leje_q;
  logic [IDX_W-1:0]   s_q;
  logic               zene_q;
  logic [IDX_W-1:0]   ptr_q;

  logic               win_found_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [IDX_W-1:0]   cand_c;
  logic               hold_hit_c;
  logic               release_c;

  // Round-robin search: first requester at or above ptr, wrapping 7->0.
  // Scanning offsets downward leaves the smallest offset as the winner.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand_c = IDX_W'(ptr_q + IDX_W'(k));
      if (Kerkesa[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q;
  logic             timeout_q;

  assign hold_hit_c = (hold_q == CNT_W'(MAX_HOLD - 1));

  // Hold counter: zero while idle so it starts cleared on each new grant.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hold_q <= '0;
    end else if (state_q == ST_IDLE) begin
      hold_q <= '0;
    end else if (hold_q != '1) begin
      hold_q <= hold_q + CNT_W'(1);
    end
  end

  // One-cycle pulse alongside a forced release, even if Liro also fired.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == ST_OWN) && hold_hit_c;
    end
  end

  assign Timeout = timeout_q;
`else
  assign hold_hit_c = 1'b0;
  assign Timeout    = 1'b0;
`endif

  // Owner gives up the bus on strobe, on dropping its request, or on timeout.
  assign release_c = Liro | ~Kerkesa[s_q] | hold_hit_c;

  // Arbitration FSM with registered grant, select, busy and pointer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      leje_q  <= '0;
      s_q     <= '0;
      zene_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found_c) begin
            state_q <= ST_OWN;
            leje_q  <= N'(1) << win_idx_c;
            s_q     <= win_idx_c;
            zene_q  <= 1'b1;
          end
        end
        ST_OWN: begin
          if (release_c) begin
            state_q <= ST_IDLE;
            leje_q  <= '0;
            zene_q  <= 1'b0;
            ptr_q   <= IDX_W'(s_q + IDX_W'(1));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          leje_q  <= '0;
          zene_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Leje = leje_q;
  assign s    = s_q;
  assign Zene = zene_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Testbench for bus_arbiter8: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural arbiter model.
module tb_bus_arbiter8;

  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Kerkesa;
  logic       Liro;
  logic [7:0] Leje;
  logic [2:0] s;
  logic       Zene;
  logic       Timeout;

  int tests = 0;
  int fails = 0;

  // Behavioural model: owner index (-1 when nobody owns the bus).
  int         m_owner;
  int         m_ptr;
  int         m_hold;
  logic [2:0] m_s;
  logic       m_to;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] leje;
    logic [2:0] sel;
    logic       zene;
    logic       to;
  } vec_t;

  vec_t vecs[14];

  bus_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Kerkesa (Kerkesa),
    .Liro    (Liro),
    .Leje    (Leje),
    .s       (s),
    .Zene    (Zene),
    .Timeout (Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] leje, input logic [2:0] sel,
                            input logic zene, input logic to);
    check({tag, " Leje"}, Leje, leje);
    check({tag, " s"}, 8'(s), 8'(sel));
    check({tag, " Zene"}, 8'(Zene), 8'(zene));
    check({tag, " Timeout"}, 8'(Timeout), 8'(to));
  endtask

  // One clock of the arbiter rules, evaluated on the values sampled at the edge.
  task automatic model_step();
    int  w;
    bit  forced;
    if (!Reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_s = 3'd0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      w = -1;
      for (int k = 0; k < 8; k++) begin
        if (w < 0 && Kerkesa[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_owner = w; m_s = 3'(w); m_hold = 0;
      end
    end else begin
      forced = TO_EN && (m_hold == int'(MAX_HOLD) - 1);
      if (Liro || !Kerkesa[m_owner] || forced) begin
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
        m_to = forced;
      end else begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] req, input logic rel);
    Reset = rst; Kerkesa = req; Liro = rel;
    @(posedge Clock);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_leje;
    exp_leje = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
    expect_out(tag, exp_leje, m_s, (m_owner >= 0), m_to);
  endtask

  initial begin
    logic [7:0] req;
    logic [7:0] prev_req;
    Reset = 1'b0; Kerkesa = 8'h00; Liro = 1'b0;

    // rst, req, rel -> Leje, s, Zene, Timeout after the edge
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // reset state
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // first grant, 1-cycle latency
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // release, ptr=1
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // Liro in idle ignored
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // wrap from ptr=1 to 0
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // no preemption
    vecs[6]  = '{1'b1, 8'h02, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // owner drops request
    vecs[7]  = '{1'b1, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0}; // grant 1
    vecs[8]  = '{1'b1, 8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0}; // s holds through idle
    vecs[9]  = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // ptr=2 wraps to 0
    vecs[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // all requests drop
    vecs[11] = '{1'b1, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0}; // top requester
    vecs[12] = '{1'b1, 8'h80, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0}; // release of 7
    vecs[13] = '{1'b0, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // reset clears s

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].rel);
      expect_out($sformatf("vec%0d", i), vecs[i].leje, vecs[i].sel, vecs[i].zene, vecs[i].to);
    end

    // All requesting, one release per grant: 0..7 then 0, one idle cycle between.
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    expect_out("rr g0", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int g = 1; g <= 8; g++) begin
      drive(1'b1, 8'hFF, 1'b1);
      expect_out($sformatf("rr gap%0d", g), 8'h00, 3'((g - 1) % 8), 1'b0, 1'b0);
      drive(1'b1, 8'hFF, 1'b0);
      expect_out($sformatf("rr g%0d", g), 8'(1) << (g % 8), 3'(g % 8), 1'b1, 1'b0);
    end

    // Owner 3 keeps the bus while other requests change; 7 wins afterwards.
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h08, 1'b0);
    expect_out("np grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 8'h88, 1'b0);
    expect_out("np hold3a", 8'h08, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 8'h88, 1'b0);
    expect_out("np hold3b", 8'h08, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 8'h88, 1'b1);
    expect_out("np release", 8'h00, 3'd3, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 1'b0);
    expect_out("np grant7", 8'h80, 3'd7, 1'b1, 1'b0);

    // Reset mid-ownership of 5 after ptr has moved to 4; next search starts at 0.
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h08, 1'b0);
    drive(1'b1, 8'h08, 1'b1);
    drive(1'b1, 8'h20, 1'b0);
    expect_out("rst grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    drive(1'b0, 8'h20, 1'b0);
    expect_out("rst abort", 8'h00, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 8'h21, 1'b0);
    expect_out("rst ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Held request with no release: four owner cycles, then forced release.
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    expect_out("to own0", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      drive(1'b1, 8'h04, 1'b0);
      expect_out($sformatf("to own%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    drive(1'b1, 8'h04, 1'b0);
    expect_out("to fire", 8'h00, 3'd2, 1'b0, 1'b1);
    drive(1'b1, 8'h04, 1'b0);
    expect_out("to regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    // Liro on the timeout cycle: single release, pulse still present.
    for (int c = 1; c < 4; c++) drive(1'b1, 8'h04, 1'b0);
    drive(1'b1, 8'h04, 1'b1);
    expect_out("to+liro", 8'h00, 3'd2, 1'b0, 1'b1);
    drive(1'b1, 8'h00, 1'b0);
    expect_out("to clear", 8'h00, 3'd2, 1'b0, 1'b0);
`endif

    // Randomized traffic against the model.
    drive(1'b0, 8'h00, 1'b0);
    check_model("rand reset");
    prev_req = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0:       req = 8'h00;
        1, 2:    req = 8'($urandom);
        3:       req = 8'(1) << $urandom_range(0, 7);
        default: req = prev_req;
      endcase
      prev_req = req;
      drive(($urandom_range(0, 99) != 0), req, ($urandom_range(0, 3) == 0));
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles one owner may hold the grant when the timeout is compiled in (legal range 2..255).
REQ-002 SHALL have port Clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port Reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port Kerkesa, input, 8, per-requester request; bit i is requester i.
REQ-005 SHALL have port Liro, input, 1, release strobe from the current owner.
REQ-006 SHALL have port Leje, output, 8, one-hot grant, registered.
REQ-007 SHALL have port s, output, 3, select for the shared 8:1 datapath mux; equals the index of the granted requester.
REQ-008 SHALL have port Zene, output, 1, busy: high exactly when Leje is nonzero.
REQ-009 SHALL have port Timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (Leje = 0) and OWN (Leje one-hot).
REQ-011 SHALL in IDLE, when Kerkesa is nonzero, move to OWN and assert Leje for the winner on the next edge (1-cycle grant latency).
REQ-012 SHALL pick the winner round-robin: the first set bit of Kerkesa searching upward from ptr, wrapping 7->0.
REQ-013 SHALL set ptr = (owner + 1) mod 8 on every release, so the released owner has lowest priority next.
REQ-014 SHALL in OWN leave to IDLE on the next edge when Liro = 1 or Kerkesa[owner] = 0; Leje = 0 for exactly one turnaround cycle before the next grant.
REQ-015 SHALL ignore Liro while in IDLE.
REQ-016 SHALL ignore changes to non-owner Kerkesa bits while in OWN; no preemption.
REQ-017 SHALL update s together with Leje on grant and hold the last owner's index through IDLE.
REQ-018 SHALL keep a hold counter, cleared on entry to OWN and incremented each OWN cycle, saturating at 255.
REQ-019 SHALL treat Liro and Timeout in the same cycle as a single release with Timeout still pulsed.

Reset
REQ-020 SHALL, when Reset = 0 at a rising edge, set state IDLE, Leje = 0, s = 0, Zene = 0, Timeout = 0, ptr = 0 and hold counter = 0.
REQ-021 SHALL abort an ownership in progress when reset occurs mid-OWN, with no Timeout pulse.
REQ-022 SHALL leave all outputs at reset values in the first cycle after Reset returns to 1, with a grant possible one cycle later.

Configuration
REQ-023 SHALL, with macro ARB_TIMEOUT_EN defined, force a release when the hold counter reaches MAX_HOLD-1 without Liro: Leje drops on the next edge, Timeout pulses for one cycle, and ptr advances per REQ-013.
REQ-024 SHALL, without ARB_TIMEOUT_EN, drive Timeout constant 0 and hold ownership indefinitely until Liro or request drop, with the counter logic removed.

Verification
REQ-025 SHALL cover: after reset, Kerkesa = 8'h01 at cycle 0 -> Leje = 8'h01, s = 0, Zene = 1 at cycle 1.
REQ-026 SHALL cover: Kerkesa = 8'hFF held, Liro pulsed once per grant -> grants in order 0,1,2,...,7,0, each separated by one Leje = 0 cycle.
REQ-027 SHALL cover: owner 3 holding, Kerkesa changes to 8'h88 -> no change in grant until Liro; next grant goes to 7.
REQ-028 SHALL cover: with ARB_TIMEOUT_EN and MAX_HOLD = 4, Kerkesa = 8'h04 held and no Liro -> Leje = 8'h04 for 4 cycles, then Timeout = 1 with Leje = 0, then regrant to 2.
REQ-029 SHALL cover: Reset = 0 asserted while owner 5 is granted -> next cycle Leje = 0, s = 0, Timeout = 0, and the next arbitration starts from ptr = 0.
REQ-030 SHALL cover: Liro = 1 while in IDLE with Kerkesa = 0 -> Leje stays 0 and ptr is unchanged.
